cv_tile_sequencer: RTL and testbench

//  Upstream command sequencer for CVDataLoader. Walks one conv layer tile by tile and drives the

---
 rtl/cv_tile_sequencer.sv | 176 +++++++++++++++++
 tb/tb_cv_tile_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cv_tile_sequencer.sv
// Command sequencer for CVDataLoader: walks a conv layer O-tile / H-tile / W-tile / I-tile
// and drives the loader's tile coordinates plus load_weight/load_input/store_output.
module cv_tile_sequencer #(
  parameter  int unsigned CW = 13,
  localparam int unsigned DW = 11,
  localparam int unsigned KW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] I,
  input  logic [DW-1:0] O,
  input  logic [DW-1:0] H,
  input  logic [DW-1:0] W,
  input  logic [KW-1:0] K,
  input  logic [1:0]    pad,
  input  logic [DW-1:0] TI,
  input  logic [DW-1:0] TO,
  input  logic [DW-1:0] TH,
  input  logic [DW-1:0] TW,
  input  logic          dl_done,
  output logic          load_weight,
  output logic          load_input,
  output logic          store_output,
  output logic [CW-1:0] Iext,
  output logic [CW-1:0] Oext,
  output logic [CW-1:0] Hext,
  output logic [CW-1:0] Wext,
  output logic [CW-1:0] Iori,
  output logic [CW-1:0] Oori,
  output logic [CW-1:0] Hori,
  output logic [CW-1:0] Wori,
  output logic          busy,
  output logic          finished,
  output logic          cfg_err
);

  typedef enum logic [2:0] {S_IDLE, S_LW, S_LIF, S_SOF, S_FINISH} state_t;

  state_t state, state_nxt;

  logic [CW-1:0] c_i, c_o, c_k, c_pad, c_ti, c_to, c_th, c_tw, c_hp, c_wp;
  logic [CW-1:0] n_i, n_o, n_k, n_pad, n_ti, n_to, n_th, n_tw, n_hp, n_wp;
  logic [CW-1:0] o_t, h_t, w_t, i_t, o_n, h_n, w_n, i_n;
  logic [CW-1:0] in_hp, in_wp;
  logic [CW-1:0] rem_i, rem_o, rem_h, rem_w;
  logic [CW-1:0] iext_d, oext_d, hext_d, wext_d, hori_d, wori_d;
  logic          in_bad, accept, cmd_act, adv;
  logic          lw_d, li_d, so_d, busy_d, fin_d;

  // Output dims of the incoming layer; sign bit set means the window does not fit.
  assign in_hp = CW'(H) + CW'(pad) + CW'(pad) + CW'(1) - CW'(K);
  assign in_wp = CW'(W) + CW'(pad) + CW'(pad) + CW'(1) - CW'(K);

  assign in_bad = (TI == '0) || (TO == '0) || (TH == '0) || (TW == '0) ||
                  (I == '0) || (O == '0) || (K == '0) ||
                  in_hp[CW-1] || (in_hp == '0) || in_wp[CW-1] || (in_wp == '0);

  assign accept  = (state == S_IDLE) && start;
  assign cmd_act = load_weight | load_input | store_output;
  // dl_done only counts while a command is actually presented to the loader.
  assign adv     = dl_done && cmd_act;

  always_comb begin : cfg_next
    n_i = c_i;  n_o = c_o;  n_k = c_k;  n_pad = c_pad;
    n_ti = c_ti; n_to = c_to; n_th = c_th; n_tw = c_tw;
    n_hp = c_hp; n_wp = c_wp;
    if (accept) begin
      n_i = CW'(I);   n_o = CW'(O);   n_k = CW'(K);   n_pad = CW'(pad);
      n_ti = CW'(TI); n_to = CW'(TO); n_th = CW'(TH); n_tw = CW'(TW);
      n_hp = in_hp;   n_wp = in_wp;
    end
  end

  always_ff @(posedge clk or negedge rst) begin : state_reg
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin : next_state
    state_nxt = state;
    o_n = o_t; h_n = h_t; w_n = w_t; i_n = i_t;
    unique case (state)
      S_IDLE: if (start) begin
        o_n = '0; h_n = '0; w_n = '0; i_n = '0;
        state_nxt = in_bad ? S_FINISH : S_LW;
      end
      S_LW: if (adv) state_nxt = S_LIF;
      S_LIF: if (adv) begin
        if (i_t + c_ti >= c_i) begin
          i_n = '0;
          state_nxt = S_SOF;
        end else begin
          i_n = i_t + c_ti;
        end
      end
      S_SOF: if (adv) begin
        if (w_t + c_tw < c_wp) begin
          w_n = w_t + c_tw;
          state_nxt = S_LIF;
        end else begin
          w_n = '0;
          if (h_t + c_th < c_hp) begin
            h_n = h_t + c_th;
            state_nxt = S_LIF;
          end else begin
            h_n = '0;
            if (o_t + c_to < c_o) begin
              o_n = o_t + c_to;
              state_nxt = S_LW;
            end else begin
              o_n = '0;
              state_nxt = S_FINISH;
            end
          end
        end
      end
      S_FINISH: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Command bits drop for one cycle after each accepted dl_done, even when the state repeats.
  always_comb begin : out_dec
    lw_d   = (state_nxt == S_LW)  && !adv;
    li_d   = (state_nxt == S_LIF) && !adv;
    so_d   = (state_nxt == S_SOF) && !adv;
    busy_d = (state_nxt == S_LW) || (state_nxt == S_LIF) || (state_nxt == S_SOF);
    fin_d  = (state_nxt == S_FINISH);
    rem_i  = n_i - i_n;
    rem_o  = n_o - o_n;
    rem_h  = n_hp - h_n;
    rem_w  = n_wp - w_n;
    iext_d = (n_ti < rem_i) ? n_ti : rem_i;
    oext_d = (n_to < rem_o) ? n_to : rem_o;
    hext_d = ((n_th < rem_h) ? n_th : rem_h) + n_k - CW'(1);
    wext_d = ((n_tw < rem_w) ? n_tw : rem_w) + n_k - CW'(1);
    hori_d = h_n - n_pad;
    wori_d = w_n - n_pad;
  end

  always_ff @(posedge clk or negedge rst) begin : cfg_cnt_reg
    if (!rst) begin
      c_i <= '0; c_o <= '0; c_k <= '0; c_pad <= '0;
      c_ti <= '0; c_to <= '0; c_th <= '0; c_tw <= '0;
      c_hp <= '0; c_wp <= '0;
      o_t <= '0; h_t <= '0; w_t <= '0; i_t <= '0;
    end else begin
      c_i <= n_i; c_o <= n_o; c_k <= n_k; c_pad <= n_pad;
      c_ti <= n_ti; c_to <= n_to; c_th <= n_th; c_tw <= n_tw;
      c_hp <= n_hp; c_wp <= n_wp;
      o_t <= o_n; h_t <= h_n; w_t <= w_n; i_t <= i_n;
    end
  end

  always_ff @(posedge clk or negedge rst) begin : out_reg
    if (!rst) begin
      load_weight <= 1'b0; load_input <= 1'b0; store_output <= 1'b0;
      busy <= 1'b0; finished <= 1'b0; cfg_err <= 1'b0;
      Iext <= '0; Oext <= '0; Hext <= '0; Wext <= '0;
      Iori <= '0; Oori <= '0; Hori <= '0; Wori <= '0;
    end else begin
      load_weight  <= lw_d;
      load_input   <= li_d;
      store_output <= so_d;
      busy         <= busy_d;
      finished     <= fin_d;
      if (accept) cfg_err <= in_bad;
      if (busy_d) begin
        Iext <= iext_d; Oext <= oext_d; Hext <= hext_d; Wext <= wext_d;
        Iori <= i_n;    Oori <= o_n;    Hori <= hori_d; Wori <= wori_d;
      end
    end
  end

endmodule

// File: tb/tb_cv_tile_sequencer.sv
// Bench for cv_tile_sequencer: a loop-nest model of the layer walk, a randomized loader
// and a per-cycle monitor comparing every presented command and its tile signals.
module tb_cv_tile_sequencer;

  logic        clk, rst, start, dl_done;
  logic [10:0] cfg_i, cfg_o, cfg_h, cfg_w, cfg_ti, cfg_to, cfg_th, cfg_tw;
  logic [4:0]  cfg_k;
  logic [1:0]  cfg_pad;
  logic        load_weight, load_input, store_output, busy, finished, cfg_err;
  logic [12:0] Iext, Oext, Hext, Wext, Iori, Oori, Hori, Wori;

  cv_tile_sequencer #(.CW(13)) dut (
    .clk(clk), .rst(rst), .start(start),
    .I(cfg_i), .O(cfg_o), .H(cfg_h), .W(cfg_w), .K(cfg_k), .pad(cfg_pad),
    .TI(cfg_ti), .TO(cfg_to), .TH(cfg_th), .TW(cfg_tw),
    .dl_done(dl_done),
    .load_weight(load_weight), .load_input(load_input), .store_output(store_output),
    .Iext(Iext), .Oext(Oext), .Hext(Hext), .Wext(Wext),
    .Iori(Iori), .Oori(Oori), .Hori(Hori), .Wori(Wori),
    .busy(busy), .finished(finished), .cfg_err(cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          cmd;  // 1 = load_weight, 2 = load_input, 3 = store_output
    logic [12:0] ie, oe, he, we, io, oo, ho, wo;
  } tr_t;

  tr_t q[$];
  int  total = 0, bad = 0;
  int  L_I, L_O, L_H, L_W, L_K, L_P, L_TI, L_TO, L_TH, L_TW, L_HP, L_WP;
  int  maxd = 0;
  bit  mon_en = 0, pend_low = 0;
  logic [2:0] pend_mask = '0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int mn(int a, int b);
    return (a < b) ? a : b;
  endfunction

  function automatic tr_t mk(int c, int i, int o, int h, int w);
    tr_t t;
    t.cmd = c;
    t.ie = 13'(mn(L_TI, L_I - i));
    t.oe = 13'(mn(L_TO, L_O - o));
    t.he = 13'(mn(L_TH, L_HP - h) + L_K - 1);
    t.we = 13'(mn(L_TW, L_WP - w) + L_K - 1);
    t.io = 13'(i);
    t.oo = 13'(o);
    t.ho = 13'(h - L_P);
    t.wo = 13'(w - L_P);
    return t;
  endfunction

  // Expected command stream straight from the loop nest of the layer walk.
  function automatic void build();
    q.delete();
    for (int o = 0; o < L_O; o += L_TO) begin
      q.push_back(mk(1, 0, o, 0, 0));
      for (int h = 0; h < L_HP; h += L_TH)
        for (int w = 0; w < L_WP; w += L_TW) begin
          for (int i = 0; i < L_I; i += L_TI) q.push_back(mk(2, i, o, h, w));
          q.push_back(mk(3, 0, o, h, w));
        end
    end
  endfunction

  task automatic set_layer(input int i, o, h, w, k, p, ti, to, th, tw);
    L_I = i; L_O = o; L_H = h; L_W = w; L_K = k; L_P = p;
    L_TI = ti; L_TO = to; L_TH = th; L_TW = tw;
    L_HP = h + 2 * p - k + 1;
    L_WP = w + 2 * p - k + 1;
    cfg_i = 11'(i); cfg_o = 11'(o); cfg_h = 11'(h); cfg_w = 11'(w);
    cfg_k = 5'(k); cfg_pad = 2'(p);
    cfg_ti = 11'(ti); cfg_to = 11'(to); cfg_th = 11'(th); cfg_tw = 11'(tw);
  endtask

  // Monitor + loader: check at the falling edge, then decide this cycle's dl_done.
  initial begin
    bit   armed;
    int   dly, ncmd, cur;
    logic [2:0] cv;
    tr_t  e;
    armed = 0; dly = 0; dl_done = 1'b0;
    forever begin
      @(negedge clk);
      cv   = {load_weight, load_input, store_output};
      ncmd = int'(load_weight) + int'(load_input) + int'(store_output);
      cur  = load_weight ? 1 : load_input ? 2 : store_output ? 3 : 0;
      if (mon_en && rst) begin
        if (pend_low) begin
          chk("cmd_low_after_done", cv & pend_mask, 3'b000);
          pend_low = 0;
        end
        chk("one_cmd_at_a_time", ncmd <= 1, 1'b1);
        if (ncmd != 0) begin
          chk("busy_with_cmd", busy, 1'b1);
          if (q.size() == 0) chk("unexpected_cmd", cur, 0);
          else begin
            e = q[0];
            chk("cmd_kind", cur, e.cmd);
            chk("tile_sig", {Iext, Oext, Hext, Wext, Iori, Oori, Hori, Wori},
                {e.ie, e.oe, e.he, e.we, e.io, e.oo, e.ho, e.wo});
          end
        end
        if (finished) begin
          chk("finish_all_tiles_done", q.size(), 0);
          chk("busy_low_at_finish", busy, 1'b0);
        end
      end
      dl_done = 1'b0;
      if (ncmd == 0) armed = 0;
      else if (!armed) begin armed = 1; dly = $urandom_range(0, maxd); end
      if (armed) begin
        if (dly == 0) begin
          dl_done = 1'b1;
          armed = 0;
          if (mon_en && q.size() > 0) void'(q.pop_front());
          pend_low = 1; pend_mask = cv;
        end else dly--;
      end else if (!busy && $urandom_range(0, 3) == 0) dl_done = 1'b1;
    end
  end

  task automatic run_layer(input int md, input bit mid);
    bit done;
    int midc;
    repeat (2) @(negedge clk);
    build();
    maxd = md; pend_low = 0; mon_en = 1;
    start = 1'b1;
    @(negedge clk);
    done = 0;
    midc = $urandom_range(2, 30);
    for (int c = 0; c < 30000; c++) begin
      if (finished) begin done = 1; break; end
      start = mid && (c == midc) && busy;
      @(negedge clk);
    end
    start = 1'b0;
    chk("layer_finished", done, 1'b1);
    chk("cfg_err_clear", cfg_err, 1'b0);
    chk("model_drained", q.size(), 0);
  endtask

  task automatic run_bad();
    repeat (2) @(negedge clk);
    q.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("bad_finished", finished, 1'b1);
    chk("bad_cfg_err", cfg_err, 1'b1);
    chk("bad_busy", busy, 1'b0);
    @(negedge clk);
    chk("bad_finish_pulse_end", finished, 1'b0);
    repeat (3) @(negedge clk);
    chk("cfg_err_sticky", cfg_err, 1'b1);
  endtask

  initial begin
    int nlw;
    bit seen;
    int k, p, lo;
    rst = 1'b0; start = 1'b0;
    set_layer(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #12;
    chk("rst_load_weight", load_weight, 1'b0);
    chk("rst_load_input", load_input, 1'b0);
    chk("rst_store_output", store_output, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_finished", finished, 1'b0);
    chk("rst_cfg_err", cfg_err, 1'b0);
    chk("rst_tile", {Iext, Oext, Hext, Wext, Iori, Oori, Hori, Wori}, 104'd0);
    @(negedge clk);
    rst = 1'b1;
    mon_en = 1;

    // Single-tile layer.
    set_layer(4, 8, 6, 6, 3, 1, 4, 8, 6, 6);
    build();
    chk("m1_len", q.size(), 3);
    chk("m1_lif_hext", q[1].he, 13'd8);
    chk("m1_lif_hori", q[1].ho, 13'h1FFF);
    run_layer(3, 0);

    // Multi-tile layer with clipped edge tiles.
    set_layer(4, 8, 6, 6, 3, 1, 3, 5, 4, 4);
    build();
    nlw = 0;
    foreach (q[j]) if (q[j].cmd == 1) nlw++;
    chk("m2_len", q.size(), 26);
    chk("m2_lw_count", nlw, 2);
    chk("m2_iext_first", q[1].ie, 13'd3);
    chk("m2_iext_second", q[2].ie, 13'd1);
    chk("m2_oext_first", q[0].oe, 13'd5);
    chk("m2_oext_second", q[13].oe, 13'd3);
    chk("m2_last_hext", q[25].he, 13'd4);
    chk("m2_last_wext", q[25].we, 13'd4);
    run_layer(0, 0);
    run_layer(20, 1);

    // Degenerate configurations.
    set_layer(4, 8, 4, 4, 7, 1, 3, 5, 4, 4);
    run_bad();
    set_layer(4, 8, 6, 6, 3, 1, 3, 0, 4, 4);
    run_bad();

    // Random layers with random loader latency and stray starts.
    for (int n = 0; n < 6; n++) begin
      k = $urandom_range(1, 5);
      p = $urandom_range(0, 2);
      lo = (k - 2 * p < 1) ? 1 : k - 2 * p;
      set_layer($urandom_range(1, 6), $urandom_range(1, 6), $urandom_range(lo, lo + 6),
                $urandom_range(lo, lo + 6), k, p, $urandom_range(2, 4),
                $urandom_range(2, 6), $urandom_range(2, 5), $urandom_range(2, 5));
      run_layer($urandom_range(0, 8), 1);
    end

    // Reset while an input tile is being loaded, then a clean layer from scratch.
    set_layer(4, 8, 6, 6, 3, 1, 3, 5, 4, 4);
    repeat (2) @(negedge clk);
    build();
    maxd = 3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    for (int c = 0; c < 500; c++) begin
      if (load_input) begin seen = 1; break; end
      @(negedge clk);
    end
    chk("reached_lif", seen, 1'b1);
    #2;
    mon_en = 0;
    rst = 1'b0;
    #1;
    chk("arst_load_input", load_input, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_other_cmds", {load_weight, store_output, finished}, 3'b000);
    @(negedge clk);
    rst = 1'b1;
    run_layer(4, 0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
